// File: rtl/accel_text_pkg.sv
// rtl/accel_text_pkg.sv - shared constants, geometry helpers and FSM states for the accelerometer text formatter
package accel_text_pkg;

   localparam int DATA_W   = 10;
   localparam int ORIGIN_X = 40;
   localparam int ORIGIN_Y = 60;
   localparam int GLYPH_W  = 60;
   localparam int GLYPH_H  = 100;
   localparam int CELL_GAP = 20;
   localparam int PITCH_X  = GLYPH_W + CELL_GAP;
   localparam int PITCH_Y  = GLYPH_H + CELL_GAP;
   localparam int NUM_ROWS = 3;
   localparam int NUM_COLS = 6;

   localparam logic [7:0] ASC_X     = 8'h58;
   localparam logic [7:0] ASC_Y     = 8'h59;
   localparam logic [7:0] ASC_Z     = 8'h5A;
   localparam logic [7:0] ASC_EQ    = 8'h3D;
   localparam logic [7:0] ASC_MINUS = 8'h2D;
   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_ZERO  = 8'h30;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_STORE,
      ST_DONE
   } state_t;

   // Left/top pixel edge of cell c; c == count gives the far edge of the grid.
   function automatic logic [9:0] cell_x(input int c);
      return 10'(ORIGIN_X + c * PITCH_X);
   endfunction

   function automatic logic [9:0] cell_y(input int r);
      return 10'(ORIGIN_Y + r * PITCH_Y);
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - iterative double-dabble converter, one shift-add-3 step per cycle
module bin2bcd_serial
   import accel_text_pkg::*;
#(
   parameter int WIDTH = DATA_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] mag,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bcd_hund,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] bin_q;
   logic [11:0]      bcd_q;
   logic [11:0]      bcd_adj;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < 3; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5)
            bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
   end

   // Asserted during the final step so the caller sees settled digits next cycle.
   assign done = busy && (cnt_q == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= 1'b0;
         cnt_q <= '0;
         bin_q <= '0;
         bcd_q <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt_q <= CNT_W'(WIDTH);
         bin_q <= mag;
         bcd_q <= '0;
      end else if (busy) begin
         {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
         cnt_q          <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1))
            busy <= 1'b0;
      end
   end

   assign bcd_hund = bcd_q[11:8];
   assign bcd_tens = bcd_q[7:4];
   assign bcd_ones = bcd_q[3:0];

endmodule

// File: rtl/accel_text_formatter.sv
// rtl/accel_text_formatter.sv - converts xyz samples to a 3x6 text buffer and serves glyph lookups per pixel
module accel_text_formatter
   import accel_text_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [DATA_W-1:0] ax,
   input  logic [DATA_W-1:0] ay,
   input  logic [DATA_W-1:0] az,
   input  logic              frame_start,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   output logic [7:0]        char_code,
   output logic [9:0]        base_x,
   output logic [9:0]        base_y,
   output logic [9:0]        x_out,
   output logic [9:0]        y_out,
   output logic              conv_done
);

   state_t state_q, state_d;
   logic [1:0] axis_q;
   logic       pending_q;
   logic       bcd_start, bcd_busy, bcd_done;
   logic [3:0] bcd_hund, bcd_tens, bcd_ones;

   logic [NUM_ROWS-1:0][DATA_W-1:0] sample_q;
   logic [DATA_W-1:0]               cur_val, cur_mag;
   logic                            cur_neg;

   // Only the variable part of each row is stored: sign flag plus three BCD digits.
   logic [NUM_ROWS-1:0]       sh_neg, dp_neg;
   logic [NUM_ROWS-1:0][11:0] sh_bcd, dp_bcd;

   always_comb begin
      case (axis_q)
         2'd1:    cur_val = sample_q[1];
         2'd2:    cur_val = sample_q[2];
         default: cur_val = sample_q[0];
      endcase
      cur_neg = cur_val[DATA_W-1];
      cur_mag = cur_neg ? (~cur_val + DATA_W'(1)) : cur_val;
   end

   bin2bcd_serial #(.WIDTH(DATA_W)) u_bcd (
      .clk      (clk),
      .reset    (reset),
      .start    (bcd_start),
      .mag      (cur_mag),
      .busy     (bcd_busy),
      .done     (bcd_done),
      .bcd_hund (bcd_hund),
      .bcd_tens (bcd_tens),
      .bcd_ones (bcd_ones)
   );

   assign sample_ready = (state_q == ST_IDLE) && !pending_q && !bcd_busy;
   assign conv_done    = (state_q == ST_DONE);

   always_comb begin
      state_d   = state_q;
      bcd_start = 1'b0;
      case (state_q)
         ST_IDLE:  if (sample_valid && sample_ready) state_d = ST_LOAD;
         ST_LOAD: begin
            bcd_start = 1'b1;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: if (bcd_done) state_d = ST_STORE;
         ST_STORE: state_d = (axis_q == 2'd2) ? ST_DONE : ST_LOAD;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         axis_q    <= 2'd0;
         pending_q <= 1'b0;
         sample_q  <= '0;
         sh_neg    <= '0;
         sh_bcd    <= '0;
         dp_neg    <= '0;
         dp_bcd    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && sample_valid && sample_ready) begin
            sample_q <= {az, ay, ax};
            axis_q   <= 2'd0;
         end
         if (state_q == ST_STORE) begin
            sh_neg[axis_q] <= cur_neg;
            sh_bcd[axis_q] <= {bcd_hund, bcd_tens, bcd_ones};
            axis_q         <= axis_q + 2'd1;
         end
         // pending is still low while in DONE, so a coincident frame_start cannot swap.
         if (state_q == ST_DONE) begin
            pending_q <= 1'b1;
         end else if (frame_start && pending_q) begin
            dp_neg    <= sh_neg;
            dp_bcd    <= sh_bcd;
            pending_q <= 1'b0;
         end
      end
   end

   logic [NUM_COLS-1:0] col_hit;
   logic [NUM_ROWS-1:0] row_hit;
   logic [2:0]          col_idx;
   logic [1:0]          row_idx;
   logic                in_grid;
   logic [7:0]          cell_char;

   always_comb begin
      col_hit = '0;
      row_hit = '0;
      col_idx = 3'd0;
      row_idx = 2'd0;
      for (int c = 0; c < NUM_COLS; c++)
         col_hit[c] = (pixel_x >= cell_x(c)) && (pixel_x < cell_x(c + 1));
      for (int r = 0; r < NUM_ROWS; r++)
         row_hit[r] = (pixel_y >= cell_y(r)) && (pixel_y < cell_y(r + 1));
      for (int c = 0; c < NUM_COLS; c++)
         if (col_hit[c]) col_idx = 3'(c);
      for (int r = 0; r < NUM_ROWS; r++)
         if (row_hit[r]) row_idx = 2'(r);
      in_grid = (|col_hit) && (|row_hit);

      case (col_idx)
         3'd0: begin
            case (row_idx)
               2'd1:    cell_char = ASC_Y;
               2'd2:    cell_char = ASC_Z;
               default: cell_char = ASC_X;
            endcase
         end
         3'd1:    cell_char = ASC_EQ;
         3'd2:    cell_char = dp_neg[row_idx] ? ASC_MINUS : ASC_SPACE;
         3'd3:    cell_char = ASC_ZERO + {4'h0, dp_bcd[row_idx][11:8]};
         3'd4:    cell_char = ASC_ZERO + {4'h0, dp_bcd[row_idx][7:4]};
         3'd5:    cell_char = ASC_ZERO + {4'h0, dp_bcd[row_idx][3:0]};
         default: cell_char = ASC_SPACE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         char_code <= ASC_SPACE;
         base_x    <= '0;
         base_y    <= '0;
         x_out     <= '0;
         y_out     <= '0;
      end else begin
         x_out <= pixel_x;
         y_out <= pixel_y;
         if (in_grid) begin
            char_code <= cell_char;
            base_x    <= cell_x(int'(col_idx));
            base_y    <= cell_y(int'(row_idx));
         end else begin
            char_code <= ASC_SPACE;
            base_x    <= '0;
            base_y    <= '0;
         end
      end
   end

endmodule
